// File: rtl/psum_accumulator.sv
// psum_accumulator
// Sums TILES signed partial sums from the CiM macro output register bank
// into one ACC_W-bit result, then holds that result on a valid/ready
// handshake until the requantisation stage takes it.
//
// Build option: define PSUM_ACC_SAT_EN to make the accumulator saturate on
// signed overflow and report it on ovf_o. Without it, the sum wraps modulo
// 2^ACC_W and ovf_o is tied low.
module psum_accumulator #(
  parameter int PSUM_W = 16,
  parameter int ACC_W  = 24,
  parameter int TILES  = 8
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              psum_valid_i,
  output logic              psum_ready_o,
  input  logic [PSUM_W-1:0] psum_i,
  output logic              acc_valid_o,
  input  logic              acc_ready_i,
  output logic [ACC_W-1:0]  acc_data_o,
  output logic              ovf_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(TILES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic        [CNT_W-1:0]  cnt_q;
  logic signed [ACC_W-1:0]  psum_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     sum_ovf;
  logic                     beat_acc;
  logic                     handoff;

  // Partial sum is signed; widen it with its sign bit before adding.
  assign psum_ext = ACC_W'($signed(psum_i));

  assign beat_acc = psum_valid_i && psum_ready_o;
  assign handoff  = acc_valid_o && acc_ready_i;

`ifdef PSUM_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum_wide;
  logic           ovf_q;

  // One guard bit: the top two bits disagree exactly when the true sum
  // left the ACC_W signed range, and the top bit tells which side.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {psum_ext[ACC_W-1], psum_ext};
    sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (!sum_ovf) begin
      acc_next = sum_wide[ACC_W-1:0];
    end else if (sum_wide[ACC_W]) begin
      acc_next = ACC_MIN;
    end else begin
      acc_next = ACC_MAX;
    end
  end

  // Overflow flag is sticky for the frame and restarts with each first beat.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
    end else if (clear_i) begin
      ovf_q <= 1'b0;
    end else if (beat_acc) begin
      ovf_q <= (state_q == S_IDLE) ? 1'b0 : (ovf_q | sum_ovf);
    end
  end

  assign ovf_o = ovf_q;
`else
  // Plain two's-complement wrap; overflow is never reported.
  always_comb begin
    acc_next = acc_q + psum_ext;
    sum_ovf  = 1'b0;
  end

  assign ovf_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      state_q <= state_d;
    end
  end

  // Next-state decode; clear_i overrides any handshake activity.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (clear_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (beat_acc) begin
            state_d = (TILES == 1) ? S_HOLD : S_ACC;
          end
        end
        S_ACC: begin
          if (beat_acc && (cnt_q == LAST_CNT)) begin
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (handoff) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake outputs depend on state only, so acc_ready_i never reaches
  // psum_ready_o combinationally.
  always_comb begin
    psum_ready_o = 1'b0;
    acc_valid_o  = 1'b0;
    busy_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        psum_ready_o = 1'b1;
      end
      S_ACC: begin
        psum_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      S_HOLD: begin
        acc_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: begin
        psum_ready_o = 1'b0;
      end
    endcase
  end

  // Accumulator and beat counter; the first beat of a frame loads rather
  // than adds, so no explicit zeroing is needed between results.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (beat_acc) begin
      if (state_q == S_IDLE) begin
        acc_q <= psum_ext;
        cnt_q <= CNT_W'(1);
      end else begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (handoff) begin
      cnt_q <= '0;
    end
  end

  assign acc_data_o = acc_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Testbench for psum_accumulator with PSUM_W=16, ACC_W=17, TILES=4.
// Honours PSUM_ACC_SAT_EN in its reference model when the design is built
// with it.
module tb_psum_accumulator;

  localparam int PSUM_W = 16;
  localparam int ACC_W  = 17;
  localparam int TILES  = 4;

`ifdef PSUM_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam longint ACC_MAXV = 65535;
  localparam longint ACC_MINV = -65536;
  localparam longint ACC_MOD  = 131072;

  logic                     clk;
  logic                     rst_n_i;
  logic                     clear_i;
  logic                     psum_valid_i;
  logic                     psum_ready_o;
  logic [PSUM_W-1:0]        psum_i;
  logic                     acc_valid_o;
  logic                     acc_ready_i;
  logic signed [ACC_W-1:0]  acc_data_o;
  logic                     ovf_o;
  logic                     busy_o;

  int total;
  int bad;

  typedef struct {
    int     b[TILES];
    int     g[TILES];
    longint exp_d;
    bit     exp_o;
  } vec_t;

  psum_accumulator #(
    .PSUM_W(PSUM_W),
    .ACC_W (ACC_W),
    .TILES (TILES)
  ) dut (
    .clk         (clk),
    .rst_n_i     (rst_n_i),
    .clear_i     (clear_i),
    .psum_valid_i(psum_valid_i),
    .psum_ready_o(psum_ready_o),
    .psum_i      (psum_i),
    .acc_valid_o (acc_valid_o),
    .acc_ready_i (acc_ready_i),
    .acc_data_o  (acc_data_o),
    .ovf_o       (ovf_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: arithmetic sum of the frame, either clamped after every
  // addition or reduced into the signed ACC_W range at the end.
  function automatic longint model_sum(input int b[TILES], output bit o);
    longint s;
    o = 1'b0;
    s = b[0];
    if (SAT) begin
      for (int i = 1; i < TILES; i++) begin
        s = s + b[i];
        if (s > ACC_MAXV) begin
          s = ACC_MAXV;
          o = 1'b1;
        end else if (s < ACC_MINV) begin
          s = ACC_MINV;
          o = 1'b1;
        end
      end
    end else begin
      for (int i = 1; i < TILES; i++) s = s + b[i];
      s = ((s % ACC_MOD) + ACC_MOD) % ACC_MOD;
      if (s > ACC_MAXV) s = s - ACC_MOD;
    end
    return s;
  endfunction

  function automatic vec_t mk(input int b0, input int b1, input int b2, input int b3,
                              input int g0, input int g1, input int g2, input int g3,
                              input longint d, input bit o);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.g[0] = g0; v.g[1] = g1; v.g[2] = g2; v.g[3] = g3;
    v.exp_d = d;
    v.exp_o = o;
    return v;
  endfunction

  // Present one beat and hold it until the block takes it.
  task automatic send_beat(input int v);
    int n;
    n = 0;
    psum_i       = PSUM_W'(v);
    psum_valid_i = 1'b1;
    while (!psum_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("beat_ready_wait", psum_ready_o, 1);
    @(posedge clk); #1;
    psum_valid_i = 1'b0;
  endtask

  // Wait for the result, compare it, and hand it off.
  task automatic take_result(input string tag, input longint exp_d, input bit exp_o);
    int n;
    n = 0;
    while (!acc_valid_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid_wait"}, acc_valid_o, 1);
    check({tag, "_data"}, acc_data_o, exp_d);
    check({tag, "_ovf"}, ovf_o, exp_o);
    acc_ready_i = 1'b1;
    @(posedge clk); #1;
    acc_ready_i = 1'b0;
    check({tag, "_valid_after_handoff"}, acc_valid_o, 0);
    check({tag, "_ready_after_handoff"}, psum_ready_o, 1);
    check({tag, "_busy_after_handoff"}, busy_o, 0);
  endtask

  // Full frame with inter-beat gaps, optional early acc_ready_i and
  // optional backpressure cycles while the result is held.
  task automatic run_frame(input vec_t v, input string tag, input bit early, input int bp);
    if (early) acc_ready_i = 1'b1;
    for (int i = 0; i < TILES; i++) begin
      if (i > 0) begin
        for (int k = 0; k < v.g[i]; k++) begin
          @(posedge clk); #1;
          check({tag, "_gap_busy"}, busy_o, 1);
        end
      end
      send_beat(v.b[i]);
    end
    check({tag, "_valid_latency"}, acc_valid_o, 1);
    check({tag, "_ready_in_hold"}, psum_ready_o, 0);
    if (!early) begin
      for (int k = 0; k < bp; k++) begin
        @(posedge clk); #1;
        check({tag, "_bp_valid"}, acc_valid_o, 1);
        check({tag, "_bp_data"}, acc_data_o, v.exp_d);
      end
    end
    take_result(tag, v.exp_d, v.exp_o);
  endtask

  vec_t tbl[8];
  vec_t rv;
  bit   ro;

  initial begin
    total        = 0;
    bad          = 0;
    rst_n_i      = 1'b0;
    clear_i      = 1'b0;
    psum_valid_i = 1'b0;
    psum_i       = '0;
    acc_ready_i  = 1'b0;

    tbl[0] = mk(10, -3, 7, 100,          0, 0, 0, 0, 114, 1'b0);
    tbl[1] = mk(10, -3, 7, 100,          0, 1, 3, 2, 114, 1'b0);
    tbl[2] = mk(1, 2, 3, 4,              0, 0, 0, 0, 10, 1'b0);
    tbl[3] = mk(32767, 32767, 32767, 32767, 0, 0, 0, 0, SAT ? 65535 : -4, SAT);
    tbl[4] = mk(-32768, -32768, -32768, -32768, 0, 2, 0, 1, SAT ? -65536 : 0, SAT);
    tbl[5] = mk(-1, -1, -1, -1,          0, 2, 0, 1, -4, 1'b0);
    tbl[6] = mk(32767, 32767, -32768, -32768, 0, 0, 1, 0, -2, 1'b0);
    tbl[7] = mk(32767, 32767, 32767, -32768, 0, 0, 0, 3, SAT ? 32767 : 65533, SAT);

    // Reset values.
    @(posedge clk); #1;
    check("rst_ready", psum_ready_o, 1);
    check("rst_valid", acc_valid_o, 0);
    check("rst_data", acc_data_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_busy", busy_o, 0);
    rst_n_i = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i], $sformatf("vec%0d", i), 1'b0, 0);
    end

    // Backpressure with a beat waiting; it enters only after the handoff.
    send_beat(10); send_beat(-3); send_beat(7);
    psum_i = PSUM_W'(100);
    psum_valid_i = 1'b1;
    @(posedge clk); #1;
    psum_i = PSUM_W'(5);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_valid", acc_valid_o, 1);
      check("bp_ready", psum_ready_o, 0);
      check("bp_data", acc_data_o, 114);
    end
    acc_ready_i = 1'b1;
    @(posedge clk); #1;
    acc_ready_i = 1'b0;
    check("bp_idle_valid", acc_valid_o, 0);
    check("bp_idle_ready", psum_ready_o, 1);
    @(posedge clk); #1;
    psum_valid_i = 1'b0;
    check("bp_next_busy", busy_o, 1);
    send_beat(1); send_beat(1); send_beat(1);
    take_result("bp_next", 8, 1'b0);

    // Abort mid-frame; the beat presented alongside clear_i is dropped.
    send_beat(10); send_beat(-3);
    clear_i = 1'b1;
    psum_valid_i = 1'b1;
    psum_i = PSUM_W'(55);
    @(posedge clk); #1;
    clear_i = 1'b0;
    psum_valid_i = 1'b0;
    check("clr_busy", busy_o, 0);
    check("clr_data", acc_data_o, 0);
    send_beat(1); send_beat(2); send_beat(3); send_beat(4);
    take_result("clr_frame", 10, 1'b0);

    // Abort while holding a result.
    send_beat(10); send_beat(-3); send_beat(7); send_beat(100);
    check("clrhold_valid_before", acc_valid_o, 1);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    check("clrhold_valid", acc_valid_o, 0);
    check("clrhold_ready", psum_ready_o, 1);
    check("clrhold_data", acc_data_o, 0);

    // Asynchronous reset mid-frame, applied between clock edges.
    send_beat(10); send_beat(-3); send_beat(7);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("amid_ready", psum_ready_o, 1);
    check("amid_valid", acc_valid_o, 0);
    check("amid_data", acc_data_o, 0);
    check("amid_ovf", ovf_o, 0);
    check("amid_busy", busy_o, 0);
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    run_frame(tbl[0], "after_rst", 1'b0, 0);

    // Randomised frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      logic signed [PSUM_W-1:0] r;
      for (int i = 0; i < TILES; i++) begin
        case ($urandom_range(0, 2))
          0: rv.b[i] = int'($urandom_range(0, 200)) - 100;
          1: begin
            r = PSUM_W'($urandom);
            rv.b[i] = r;
          end
          default: rv.b[i] = $urandom_range(0, 1) ? 32767 : -32768;
        endcase
        rv.g[i] = $urandom_range(0, 3);
      end
      rv.exp_d = model_sum(rv.b, ro);
      rv.exp_o = ro;
      run_frame(rv, $sformatf("rnd%0d", f), bit'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Accumulates signed partial sums from the CiM macro's registered output stage over a fixed number of tiles. One accumulated result is produced per output element and held on a valid/ready handshake toward the requantisation stage. It sits directly downstream of the enable-gated partial-sum register bank. It decouples macro tile sequencing from downstream backpressure.

## Interface
- PSUM_W, 16, width of one signed partial sum
- ACC_W, 24, width of signed accumulator and result (ACC_W ≥ PSUM_W)
- TILES, 8, partial sums per result (≥ 1)
- clk  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous abort/flush, highest priority after reset
- psum_valid_i  in  1  partial sum present
- psum_ready_o  out  1  block can accept a partial sum
- psum_i  in  PSUM_W  signed partial sum
- acc_valid_o  out  1  result valid
- acc_ready_i  in  1  downstream accepts result
- acc_data_o  out  ACC_W  signed accumulated result
- ovf_o  out  1  result saturated (qualified by acc_valid_o)
- busy_o  out  1  high in ACC or HOLD

## Operation
- Beat accepted when psum_valid_i && psum_ready_o at a rising edge; result handed off when acc_valid_o && acc_ready_i.
- psum_i is sign-extended to ACC_W before addition.
- FSM states: IDLE, ACC, HOLD. Counter cnt is $clog2(TILES+1) bits wide.
- IDLE: psum_ready_o=1. On accept: acc←sext(psum_i), cnt←1, ovf←0. Next state is HOLD if TILES==1, else ACC.
- ACC: psum_ready_o=1. On accept: acc←acc+sext(psum_i), cnt←cnt+1. If cnt==TILES-1 at the accept, go to HOLD. With no accept, state, acc and cnt are held.
- HOLD: psum_ready_o=0, acc_valid_o=1. acc_data_o and ovf_o stay stable until handoff. On handoff, go to IDLE with cnt←0.
- acc_valid_o is high only in HOLD. psum_ready_o is high only in IDLE and ACC, and is decoded from state only, with no combinational path from acc_ready_i.
- clear_i: next state IDLE, acc←0, cnt←0, ovf←0. This applies in any state, including HOLD, where the pending result is discarded. A beat presented with clear_i is dropped.
- Overflow behaviour is set by the Configuration macro.

## Timing
- Reset values: psum_ready_o=1, acc_valid_o=0, acc_data_o=0, ovf_o=0, busy_o=0. State is IDLE, cnt=0.
- Latency: acc_valid_o rises one cycle after the edge that accepts the TILES-th beat.
- Minimum period per result is TILES+1 cycles: TILES accepts plus one handoff cycle.
- psum_valid_i may bubble arbitrarily; the sum is independent of gaps.
- acc_ready_i may be high before acc_valid_o; handoff then occurs in the first HOLD cycle.
- rst_n_i assertion mid-frame clears all state immediately; the partial result is lost.

## Configuration
- PSUM_ACC_SAT_EN defined:
  - Each addition is computed at ACC_W+1 bits.
  - On signed overflow, acc clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1), and ovf is set sticky for the current result.
  - The clamped value is the base for subsequent beats.
- PSUM_ACC_SAT_EN undefined:
  - Addition wraps modulo 2^ACC_W.
  - ovf_o is tied to 0.

## Test plan
- TILES=4: psums 10, -3, 7, 100 back-to-back → psum_ready_o low and acc_valid_o high one cycle after 4th accept, acc_data_o=114, ovf_o=0.
- Backpressure: hold acc_ready_i=0 for 5 cycles with psum_valid_i=1 → acc_data_o stable at 114, no beat accepted. On acc_ready_i=1, return to IDLE the next cycle and accept the next beat.
- Bubbles: same four psums with 0–3 idle cycles between beats → acc_data_o=114, busy_o high from first accept until handoff.
- Abort: clear_i after 2 beats (10, -3), then beats 1, 2, 3, 4 → result 10. clear_i in HOLD → acc_valid_o low next cycle.
- Overflow: ACC_W=17, TILES=4, four beats of 32767 → with PSUM_ACC_SAT_EN: 65535, ovf_o=1. Without: -4 (wrapped), ovf_o=0.
- Reset mid-frame: assert rst_n_i after 3 beats → all outputs at reset values immediately. After release, a fresh 4-beat frame sums correctly.
